lifo_stack_param: RTL and testbench

Parametrised LIFO stack for the maze-solver datapath, holding visited-location words pushed by the controller and popped on backtrack. It generalises width and depth and adds the following features:
- full/empty flags and occupancy count
- sticky overflow/underflow errors
- same-cycle push+pop (replace top)
- combinational peek of the top entry
- non-destructive bottom-to-top dump mode, which streams the final path out.

---
 rtl/lifo_stack_param.sv | 131 +++++++++++++
 tb/tb_lifo_stack_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_param.sv
// rtl/lifo_stack_param.sv - parametrised LIFO stack with flags, sticky errors, peek and bottom-to-top dump
module lifo_stack_param #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic [WIDTH-1:0]  top,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf,
    input  logic              err_clr,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_valid,
    output logic              dump_last
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic {IDLE, DUMP} stateT;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   idx;
    stateT             state, stateNext;
    logic [ADDR_W-1:0] topAddr, wrAddr;
    logic              startDump, opEn, doPush, doPop, setOvf, setUnf;

    assign count   = cnt;
    assign empty   = (cnt == '0);
    assign full    = cnt[ADDR_W];
    assign topAddr = cnt[ADDR_W-1:0] - ADDR_ONE;
    assign top     = empty ? '0 : mem[topAddr];

    // A cycle that launches a dump does not also move the stack, so the dump length is the count seen here.
    assign startDump = (state == IDLE) && dump_start && !empty;
    assign opEn      = !clr && (state == IDLE) && !startDump;
    assign doPush    = opEn && push && (pop || !full);
    assign doPop     = opEn && pop && !empty;
    assign setOvf    = opEn && push && !pop && full;
    assign setUnf    = opEn && pop && empty;
    assign wrAddr    = doPop ? topAddr : cnt[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst && doPush) begin
            mem[wrAddr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            dout_valid <= doPop;
            if (doPop) begin
                dout <= mem[topAddr];
            end
            if (clr) begin
                cnt <= '0;
            end else if (doPush && !doPop) begin
                cnt <= cnt + CNT_ONE;
            end else if (doPop && !doPush) begin
                cnt <= cnt - CNT_ONE;
            end
            ovf <= setOvf || (ovf && !err_clr);
            unf <= setUnf || (unf && !err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (clr) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (startDump) stateNext = DUMP;
                DUMP:    if (dump_last) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    assign dump_busy  = (state == DUMP);
    assign dump_valid = (state == DUMP);

    // Each beat is loaded on the edge that starts it; idx points at the next word to fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            dump_data <= '0;
            dump_last <= 1'b0;
        end else if (clr) begin
            dump_last <= 1'b0;
        end else if (startDump) begin
            dump_data <= mem[0];
            dump_last <= (cnt == CNT_ONE);
            idx       <= CNT_ONE;
        end else if (state == DUMP) begin
            if (dump_last) begin
                dump_last <= 1'b0;
            end else begin
                dump_data <= mem[idx[ADDR_W-1:0]];
                dump_last <= (idx == cnt - CNT_ONE);
                idx       <= idx + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_lifo_stack_param.sv
// tb/tb_lifo_stack_param.sv - directed self-checking bench for lifo_stack_param
module tb_lifo_stack_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [7:0] top;
    logic [8:0] count;
    logic       empty, full, ovf, unf;
    logic       err_clr = 1'b0;
    logic       dump_start = 1'b0;
    logic       dump_busy;
    logic [7:0] dump_data;
    logic       dump_valid, dump_last;

    int vecCnt = 0;
    int errCnt = 0;

    lifo_stack_param #(.WIDTH(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .din(din),
        .dout(dout), .dout_valid(dout_valid), .top(top), .count(count),
        .empty(empty), .full(full), .ovf(ovf), .unf(unf), .err_clr(err_clr),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_data(dump_data),
        .dump_valid(dump_valid), .dump_last(dump_last)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doPush(input logic [7:0] d);
        push = 1'b1;
        din  = d;
        cyc();
        push = 1'b0;
    endtask

    task automatic doPop();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
    endtask

    task automatic doReset();
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        cyc();
    endtask

    logic [7:0] expPop [3];

    initial begin
        expPop[0] = 8'h33; expPop[1] = 8'h22; expPop[2] = 8'h11;

        #3;
        checkVal("rst_count", count, 0);
        checkVal("rst_empty", empty, 1);
        checkVal("rst_full", full, 0);
        checkVal("rst_dout", dout, 0);
        checkVal("rst_dvalid", dout_valid, 0);
        checkVal("rst_ovf_unf", {ovf, unf}, 0);
        checkVal("rst_dump", {dump_busy, dump_valid, dump_last}, 0);
        checkVal("rst_top", top, 0);
        cyc();
        rst = 1'b1;

        // pop from reset: refused, dout stays 0
        doPop();
        checkVal("unf_set", unf, 1);
        checkVal("unf_dout", dout, 0);
        checkVal("unf_dvalid", dout_valid, 0);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        checkVal("unf_clr", unf, 0);

        // basic push/pop order
        doPush(8'h11); doPush(8'h22); doPush(8'h33);
        checkVal("p3_count", count, 3);
        checkVal("p3_top", top, 8'h33);
        for (int i = 0; i < 3; i++) begin
            doPop();
            checkVal("pop_dout", dout, expPop[i]);
            checkVal("pop_dvalid", dout_valid, 1);
            checkVal("pop_count", count, 2 - i);
        end
        cyc();
        checkVal("pop_pulse_end", dout_valid, 0);
        checkVal("pop_empty", empty, 1);
        checkVal("pop_unf", unf, 0);

        // fill to DEPTH, overflow, then pop
        for (int i = 0; i < 256; i++) doPush(i[7:0]);
        checkVal("fill_full", full, 1);
        checkVal("fill_count", count, 256);
        checkVal("fill_empty", empty, 0);
        doPush(8'hAA);
        checkVal("ovf_set", ovf, 1);
        checkVal("ovf_count", count, 256);
        checkVal("ovf_top", top, 8'hFF);
        doPop();
        checkVal("full_pop_dout", dout, 8'hFF);
        checkVal("full_pop_full", full, 0);
        checkVal("full_pop_count", count, 255);
        clr = 1'b1; cyc(); clr = 1'b0;
        checkVal("clr_count", count, 0);
        checkVal("clr_ovf_held", ovf, 1);
        checkVal("clr_dout_held", dout, 8'hFF);
        // a new error in the same cycle as err_clr wins
        pop = 1'b1; err_clr = 1'b1; cyc(); pop = 1'b0; err_clr = 1'b0;
        checkVal("errclr_ovf", ovf, 0);
        checkVal("errclr_unf_wins", unf, 1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;

        // push+pop on empty: push done, pop refused
        push = 1'b1; pop = 1'b1; din = 8'h5A; cyc(); push = 1'b0; pop = 1'b0;
        checkVal("pp_empty_count", count, 1);
        checkVal("pp_empty_top", top, 8'h5A);
        checkVal("pp_empty_unf", unf, 1);
        checkVal("pp_empty_dvalid", dout_valid, 0);
        clr = 1'b1; err_clr = 1'b1; cyc(); clr = 1'b0; err_clr = 1'b0;

        // replace top
        doPush(8'h05); doPush(8'h06);
        push = 1'b1; pop = 1'b1; din = 8'h07; cyc(); push = 1'b0; pop = 1'b0;
        checkVal("rep_dout", dout, 8'h06);
        checkVal("rep_dvalid", dout_valid, 1);
        checkVal("rep_top", top, 8'h07);
        checkVal("rep_count", count, 2);
        checkVal("rep_ovf", ovf, 0);
        clr = 1'b1; cyc(); clr = 1'b0;

        // dump with pops held high throughout
        doPush(8'hA0); doPush(8'hB0); doPush(8'hC0);
        dump_start = 1'b1; pop = 1'b1; cyc(); dump_start = 1'b0;
        checkVal("d0_busy", {dump_busy, dump_valid}, 2'b11);
        checkVal("d0_data", dump_data, 8'hA0);
        checkVal("d0_last", dump_last, 0);
        cyc();
        checkVal("d1_data", dump_data, 8'hB0);
        checkVal("d1_last", dump_last, 0);
        cyc();
        checkVal("d2_data", dump_data, 8'hC0);
        checkVal("d2_last", dump_last, 1);
        checkVal("d2_valid", dump_valid, 1);
        cyc();
        pop = 1'b0;
        checkVal("d_end", {dump_busy, dump_valid, dump_last}, 0);
        checkVal("d_count", count, 3);
        checkVal("d_top", top, 8'hC0);
        checkVal("d_unf", unf, 0);
        checkVal("d_dvalid", dout_valid, 0);

        // dump_start on empty is a no-op
        clr = 1'b1; cyc(); clr = 1'b0;
        dump_start = 1'b1; cyc(); dump_start = 1'b0;
        checkVal("d_empty_noop", dump_busy, 0);

        // clr mid-dump
        doPush(8'h01); doPush(8'h02); doPush(8'h03);
        dump_start = 1'b1; cyc(); dump_start = 1'b0;
        checkVal("md_valid", dump_valid, 1);
        clr = 1'b1; cyc(); clr = 1'b0;
        checkVal("md_clr_valid", dump_valid, 0);
        checkVal("md_clr_busy", dump_busy, 0);
        checkVal("md_clr_count", count, 0);

        // asynchronous reset between edges
        doPush(8'h44); doPush(8'h55);
        checkVal("ar_pre_count", count, 2);
        #2 rst = 1'b0;
        #1;
        checkVal("ar_count", count, 0);
        checkVal("ar_empty", empty, 1);
        checkVal("ar_top", top, 0);
        #1 rst = 1'b1;
        cyc();
        checkVal("ar_after", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end
endmodule
